crossbar_input_scheduler: RTL and testbench
===========================================

CROSSBAR_INPUT_SCHEDULER -- requirements
Module: crossbar_input_scheduler

Interface
REQ-001 Parameter: DEPTH, 4, entries per input FIFO (power of two, >=2).
REQ-002 Port: clk  input  1  single clock; all state on rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: in1_data  input  4  port-1 payload.
REQ-005 Port: in1_dest  input  1  port-1 destination (0 = crossbar out1, 1 = out2).
REQ-006 Port: in1_valid  input  1  port-1 word offered.
REQ-007 Port: in1_ready  output  1  port-1 FIFO can accept.
REQ-008 Ports in2_data, in2_dest, in2_valid, in2_ready SHALL mirror REQ-004..007 for port 2.
REQ-009 Port: out_ready  input  1  downstream accepts the current crossbar word pair.
REQ-010 Port: xb_in1  output  4  registered data to crossbar in1.
REQ-011 Port: xb_in2  output  4  registered data to crossbar in2.
REQ-012 Port: xb_control  output  1  registered crossbar select (0 = straight in1->out1, in2->out2; 1 = cross in1->out2, in2->out1).
REQ-013 Port: out1_vld, out2_vld  output  1 each  registered; crossbar output 1/2 carries a valid word.

Function
REQ-014 Each port SHALL own a DEPTH-entry FIFO storing {dest, data}; a push occurs when inN_valid and inN_ready are both high at a rising edge.
REQ-015 inN_ready SHALL equal (FIFO count < DEPTH), combinational from state only; a full FIFO SHALL refuse a push even in a cycle that pops.
REQ-016 An issue cycle SHALL occur at a rising edge when out_ready is high or all output valids are low; otherwise all output registers and FIFOs hold.
REQ-017 In an issue cycle, with both heads valid and dests differing: both heads pop; xb_control = in1 head dest; out1_vld = out2_vld = 1.
REQ-018 In an issue cycle, with both heads valid and dests equal (conflict): only the port selected by the round-robin bit rr pops (rr=0 -> port 1, rr=1 -> port 2); rr SHALL toggle; only the destination's outN_vld is 1.
REQ-019 With exactly one head valid: that head pops; xb_control = dest for port 1, ~dest for port 2; only the destination's outN_vld is 1.
REQ-020 With no head valid in an issue cycle: xb_in1 = xb_in2 = 0, xb_control = 0, both valids 0.
REQ-021 The xb_inN of a port not popped in the issue cycle SHALL be driven 0.
REQ-022 rr SHALL change only on conflict grants; non-conflict issues leave rr unchanged.
REQ-023 A word pushed at edge N SHALL appear on outputs no earlier than edge N+1 (no combinational input-to-output path); minimum latency 1 cycle.
REQ-024 Push and pop on the same FIFO in one edge SHALL both take effect; count unchanged; pointers wrap modulo DEPTH.
REQ-025 Words from one port SHALL leave in arrival order; no word dropped or duplicated.

Reset
REQ-026 While rst_n low: FIFOs empty, rr = 0, xb_in1 = xb_in2 = 0, xb_control = 0, out1_vld = out2_vld = 0, in1_ready = in2_ready = 0.
REQ-027 Reset SHALL take effect immediately on rst_n falling, mid-operation included, discarding queued words; after release, inN_ready = 1 and the first issue occurs at the first edge with a valid head.

Verification
REQ-028 Reset release, push in1 {dest0, 0xA} and in2 {dest1, 0x5} same edge, out_ready=1 -> next edge: xb_in1=0xA, xb_in2=0x5, xb_control=0, out1_vld=out2_vld=1.
REQ-029 Push in1 {dest1, 0x3} and in2 {dest0, 0xC} -> xb_control=1, both valids 1, data 0x3/0xC.
REQ-030 Three consecutive conflicting pairs (both dest0, in1 0x1,0x2,0x3; in2 0x9,0xA,0xB) -> output order 0x1, 0x9, 0x2, 0xA, 0x3, 0xB, out1_vld only, out2_vld=0, rr alternating.
REQ-031 out_ready=0 with port 1 pushing every cycle -> in1_ready falls after DEPTH accepted words while outputs hold; raising out_ready drains in order with no loss.
REQ-032 Only in2 {dest0, 0x7} -> xb_control=1, xb_in2=0x7, xb_in1=0, out1_vld=1, out2_vld=0.
REQ-033 Assert rst_n low with 3 words queued and valids high -> all outputs 0 immediately, no queued word emerges after release.

Source files
------------

// File: rtl/crossbar_input_scheduler.sv
// Two-input crossbar front end: one FIFO per input port, and a scheduler that
// turns FIFO heads into registered crossbar data, select and output valids.
module crossbar_input_scheduler #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in1_data,
    input  logic       in1_dest,
    input  logic       in1_valid,
    output logic       in1_ready,
    input  logic [3:0] in2_data,
    input  logic       in2_dest,
    input  logic       in2_valid,
    output logic       in2_ready,
    input  logic       out_ready,
    output logic [3:0] xb_in1,
    output logic [3:0] xb_in2,
    output logic       xb_control,
    output logic       out1_vld,
    output logic       out2_vld
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [3:0] w_data     [2];
    logic       w_dest     [2];
    logic       w_valid    [2];
    logic       w_ready    [2];
    logic       w_pop      [2];
    logic       w_head_vld [2];
    logic [4:0] w_head     [2];

    assign w_data[0]  = in1_data;
    assign w_data[1]  = in2_data;
    assign w_dest[0]  = in1_dest;
    assign w_dest[1]  = in2_dest;
    assign w_valid[0] = in1_valid;
    assign w_valid[1] = in2_valid;
    assign in1_ready  = w_ready[0];
    assign in2_ready  = w_ready[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [4:0]    r_mem [DEPTH];
            logic [AW-1:0] r_wptr;
            logic [AW-1:0] r_rptr;
            logic [CW-1:0] r_count;
            logic          w_push;

            // Readiness depends on the stored count only, so a full FIFO
            // refuses a push even in a cycle where it is also popping.
            assign w_ready[gi]    = rst_n && (r_count < CW'(DEPTH));
            assign w_push         = w_valid[gi] && w_ready[gi];
            assign w_head_vld[gi] = (r_count != '0);
            assign w_head[gi]     = r_mem[r_rptr];

            always_ff @(posedge clk) begin
                if (w_push) begin
                    r_mem[r_wptr] <= {w_dest[gi], w_data[gi]};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_wptr  <= '0;
                    r_rptr  <= '0;
                    r_count <= '0;
                end else begin
                    if (w_push) begin
                        r_wptr <= r_wptr + 1'b1;
                    end
                    if (w_pop[gi]) begin
                        r_rptr <= r_rptr + 1'b1;
                    end
                    r_count <= r_count + CW'(w_push) - CW'(w_pop[gi]);
                end
            end
        end
    endgenerate

    logic       r_rr;
    logic       w_issue;
    logic       w_g1;
    logic       w_g2;
    logic       w_nx_rr;
    logic [3:0] w_nx_in1;
    logic [3:0] w_nx_in2;
    logic       w_nx_ctrl;
    logic       w_nx_v1;
    logic       w_nx_v2;

    assign w_issue = out_ready || !(out1_vld || out2_vld);

    always_comb begin
        w_g1    = 1'b0;
        w_g2    = 1'b0;
        w_nx_rr = r_rr;
        if (w_head_vld[0] && w_head_vld[1]) begin
            if (w_head[0][4] != w_head[1][4]) begin
                w_g1 = 1'b1;
                w_g2 = 1'b1;
            end else if (!r_rr) begin
                w_g1    = 1'b1;
                w_nx_rr = 1'b1;
            end else begin
                w_g2    = 1'b1;
                w_nx_rr = 1'b0;
            end
        end else begin
            w_g1 = w_head_vld[0];
            w_g2 = w_head_vld[1];
        end

        w_nx_in1  = w_g1 ? w_head[0][3:0] : 4'd0;
        w_nx_in2  = w_g2 ? w_head[1][3:0] : 4'd0;
        // Port 1 steers the select whenever it is granted; port 2 alone must
        // cross to reach out1 and go straight to reach out2.
        w_nx_ctrl = w_g1 ? w_head[0][4] : (w_g2 ? ~w_head[1][4] : 1'b0);
        w_nx_v1   = (w_g1 && !w_head[0][4]) || (w_g2 && !w_head[1][4]);
        w_nx_v2   = (w_g1 && w_head[0][4]) || (w_g2 && w_head[1][4]);

        w_pop[0]  = w_issue && w_g1;
        w_pop[1]  = w_issue && w_g2;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr       <= 1'b0;
            xb_in1     <= 4'd0;
            xb_in2     <= 4'd0;
            xb_control <= 1'b0;
            out1_vld   <= 1'b0;
            out2_vld   <= 1'b0;
        end else if (w_issue) begin
            r_rr       <= w_nx_rr;
            xb_in1     <= w_nx_in1;
            xb_in2     <= w_nx_in2;
            xb_control <= w_nx_ctrl;
            out1_vld   <= w_nx_v1;
            out2_vld   <= w_nx_v2;
        end
    end

endmodule

// File: tb/tb_crossbar_input_scheduler.sv
// Scoreboard bench: a queue-level model predicts every crossbar word pair and
// a negedge monitor compares the DUT outputs and readies against it.
module tb_crossbar_input_scheduler;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in1_data, in2_data;
    logic       in1_dest, in2_dest, in1_valid, in2_valid;
    logic       in1_ready, in2_ready;
    logic       out_ready;
    logic [3:0] xb_in1, xb_in2;
    logic       xb_control, out1_vld, out2_vld;

    crossbar_input_scheduler #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in1_data(in1_data), .in1_dest(in1_dest), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .in2_data(in2_data), .in2_dest(in2_dest), .in2_valid(in2_valid), .in2_ready(in2_ready),
        .out_ready(out_ready),
        .xb_in1(xb_in1), .xb_in2(xb_in2), .xb_control(xb_control),
        .out1_vld(out1_vld), .out2_vld(out2_vld)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic d; logic [3:0] data; } word_t;
    typedef struct packed { logic [3:0] x1; logic [3:0] x2; logic c; logic v1; logic v2; } exp_t;

    word_t q1[$];
    word_t q2[$];
    exp_t  sb[$];
    bit    m_rr;
    bit    m_vld;
    int    checks = 0;
    int    errors = 0;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: per-port word queues, round-robin only on same-dest heads.
    int    s1, s2;
    bit    g1, g2;
    exp_t  e;
    always @(posedge clk) begin
        if (!rst_n) begin
            q1.delete(); q2.delete(); sb.delete();
            m_rr = 0; m_vld = 0;
        end else begin
            s1 = q1.size();
            s2 = q2.size();
            if (out_ready || !m_vld) begin
                g1 = (s1 > 0);
                g2 = (s2 > 0);
                if (g1 && g2 && q1[0].d == q2[0].d) begin
                    if (m_rr) g1 = 0; else g2 = 0;
                    m_rr = !m_rr;
                end
                e = '0;
                if (g1) begin
                    e.x1 = q1[0].data;
                    e.c  = q1[0].d;
                    if (q1[0].d) e.v2 = 1; else e.v1 = 1;
                    void'(q1.pop_front());
                end
                if (g2) begin
                    e.x2 = q2[0].data;
                    if (!g1) e.c = !q2[0].d;
                    if (q2[0].d) e.v2 = 1; else e.v1 = 1;
                    void'(q2.pop_front());
                end
                m_vld = e.v1 || e.v2;
                if (m_vld) sb.push_back(e);
            end
            if (in1_valid && s1 < DEPTH) q1.push_back({in1_dest, in1_data});
            if (in2_valid && s2 < DEPTH) q2.push_back({in2_dest, in2_data});
        end
    end

    exp_t f;
    always @(negedge clk) begin
        if (rst_n) begin
            chk("in1_ready", in1_ready, (q1.size() < DEPTH) ? 1 : 0);
            chk("in2_ready", in2_ready, (q2.size() < DEPTH) ? 1 : 0);
            if (out1_vld || out2_vld) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    f = sb[0];
                    chk("xb_in1", xb_in1, f.x1);
                    chk("xb_in2", xb_in2, f.x2);
                    chk("xb_control", xb_control, f.c);
                    chk("out1_vld", out1_vld, f.v1);
                    chk("out2_vld", out2_vld, f.v2);
                    if (out_ready) void'(sb.pop_front());
                end
            end else begin
                chk("idle_outputs", {xb_in1, xb_in2, xb_control}, 0);
            end
        end
    end

    task automatic step(input logic v1, input logic d1, input logic [3:0] a1,
                        input logic v2, input logic d2, input logic [3:0] a2,
                        input logic ordy);
        @(posedge clk);
        #1;
        in1_valid = v1; in1_dest = d1; in1_data = a1;
        in2_valid = v2; in2_dest = d2; in2_data = a2;
        out_ready = ordy;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 4'h0, 0, 0, 4'h0, 1);
    endtask

    initial begin
        rst_n = 0;
        in1_valid = 0; in1_dest = 0; in1_data = 0;
        in2_valid = 0; in2_dest = 0; in2_data = 0;
        out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {xb_in1, xb_in2, xb_control, out1_vld, out2_vld}, 0);
        chk("reset_ready", {in1_ready, in2_ready}, 0);
        @(negedge clk);
        rst_n = 1;

        // Straight pair, directed.
        step(1, 0, 4'hA, 1, 1, 4'h5, 1);
        idle(1);
        @(posedge clk);
        @(negedge clk);
        chk("pair_straight", {xb_in1, xb_in2, xb_control, out1_vld, out2_vld}, {4'hA, 4'h5, 3'b011});

        // Port 2 alone to out1, directed.
        idle(2);
        step(0, 0, 4'h0, 1, 0, 4'h7, 1);
        idle(1);
        @(posedge clk);
        @(negedge clk);
        chk("single_in2", {xb_in1, xb_in2, xb_control, out1_vld, out2_vld}, {4'h0, 4'h7, 3'b110});

        // Crossed pair and three conflicting pairs.
        idle(2);
        step(1, 1, 4'h3, 1, 0, 4'hC, 1);
        step(1, 0, 4'h1, 1, 0, 4'h9, 1);
        step(1, 0, 4'h2, 1, 0, 4'hA, 1);
        step(1, 0, 4'h3, 1, 0, 4'hB, 1);
        idle(8);

        // Stall with port 1 pushing every cycle, then drain.
        for (int i = 0; i < 8; i++) step(1, 1'($urandom), 4'(i), 0, 0, 4'h0, 0);
        idle(12);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++)
            step(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom), ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0);
        idle(12);

        // Mid-operation reset with words queued and valids high.
        step(1, 0, 4'h1, 1, 1, 4'h2, 0);
        step(1, 1, 4'h3, 1, 0, 4'h4, 0);
        step(1, 0, 4'h5, 1, 1, 4'h6, 0);
        @(posedge clk);
        #3;
        rst_n = 0;
        #1;
        chk("async_reset_outputs", {xb_in1, xb_in2, xb_control, out1_vld, out2_vld}, 0);
        chk("async_reset_ready", {in1_ready, in2_ready}, 0);
        in1_valid = 0; in2_valid = 0; out_ready = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        idle(10);

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
